fetch_unit: RTL

//  RV32I instruction fetch stage, directly upstream of decode.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch stage. Owns the PC, issues word
//               requests to instruction memory, buffers in-order responses
//               and hands {pc, instr} to decode over valid/ready. Redirects
//               flush the buffer and squash every fetch made on the old path.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     resp_pc;       // PC belonging to the next live response
  logic [CW-1:0]   outstanding;   // granted requests not yet answered
  logic [CW-1:0]   kill;          // stale responses still to be dropped
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];

  logic [CW:0]     credit_used;
  logic            issue;
  logic            drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   kill_next;
  logic [31:0]     target;

  // Issue control, response routing and next-value arithmetic
  always_comb begin
    credit_used      = {1'b0, outstanding} + {1'b0, count};
    imem_req         = !reset && (state == FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
    imem_addr        = pc;
    issue            = imem_req && imem_gnt;
    drop             = imem_rvalid && (kill != '0);
    push             = imem_rvalid && (kill == '0) && !redirect;
    if_valid         = (count != '0);
    pop              = if_valid && if_ready && !redirect;
    outstanding_next = outstanding + CW'(issue) - CW'(imem_rvalid);
    kill_next        = drop ? (kill - CW'(1)) : kill;
    target           = redirect_pc & ~32'h3;
    if_pc            = if_valid ? fifo_pc[rd_ptr]    : 32'h0;
    if_instr         = if_valid ? fifo_instr[rd_ptr] : 32'h0;
  end

  // PC, credit counters, FIFO pointers and FETCH/DRAIN state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path
        pc      <= target;
        resp_pc <= target;
        kill    <= outstanding_next;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        state   <= (outstanding_next != '0) ? DRAIN : FETCH;
      end else begin
        if (issue) pc <= pc + 32'd4;
        kill <= kill_next;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if ((state == DRAIN) && (kill_next == '0)) state <= FETCH;
      end
    end
  end

  // Instruction buffer storage; contents only matter while marked valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  overflow_chk : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule
`default_nettype wire
